char_tx_port: RTL and testbench

CHAR_TX_PORT -- requirements
Module: char_tx_port

---
 rtl/msg_io_pkg.sv | 15 +
 rtl/char_fifo.sv | 64 ++++++
 rtl/char_tx_port.sv | 159 +++++++++++++++
 tb/tb_char_tx_port.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_io_pkg.sv
// Shared types and constants for the memory-mapped character output port.
package msg_io_pkg;

    // Transmitter frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [10:0] OUT_ADDR_DEFAULT = 11'h400;
    localparam logic [7:0]  CHAR_NUL         = 8'h00;

endpackage

// File: rtl/char_fifo.sv
// Character FIFO: power-of-two depth, natural pointer wrap, registered occupancy count.
module char_fifo import msg_io_pkg::*; #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // Guarded push/pop and pointer/count next state; push+pop leaves the count alone.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care once the count drops them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers and count, cleared asynchronously so reset discards everything queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/char_tx_port.sv
// Memory-mapped character output: store decode into a FIFO, drained by an 8N1 serial transmitter.
module char_tx_port import msg_io_pkg::*; #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [10:0] OUT_ADDR     = OUT_ADDR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       MemWrite,
    input  logic [10:0]                Addr,
    input  logic [31:0]                WriteData,
    output logic                       TxD,
    output logic                       Busy,
    output logic                       Full,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;

    logic             store_hit;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       head;
    logic [CntW-1:0]  fifo_count;
    logic             unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    // A qualifying store is a non-NUL byte written to the port address; it is dropped when full.
    always_comb begin
        store_hit  = MemWrite && (Addr == OUT_ADDR) && (WriteData[7:0] != CHAR_NUL);
        push       = store_hit && !fifo_full;
        overflow_d = overflow_q || (store_hit && fifo_full);
    end

    char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (WriteData[7:0]),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Transmitter next state: tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_q == BaudLast) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (baud_q == BaudLast) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter FSM registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign TxD      = tx_q;
    assign Busy     = (state_q != IDLE);
    assign Full     = fifo_full;
    assign Count    = fifo_count;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_char_tx_port.sv
// Bench for char_tx_port: queue-level reference model, serial-line decoder and scoreboard.
module tb_char_tx_port;

    localparam int          C    = 4;
    localparam int          D    = 8;
    localparam int          CW   = $clog2(D + 1);
    localparam logic [10:0] PORT = 11'h400;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          MemWrite  = 1'b0;
    logic [10:0]   Addr      = '0;
    logic [31:0]   WriteData = '0;
    logic          TxD;
    logic          Busy;
    logic          Full;
    logic          Overflow;
    logic [CW-1:0] Count;

    char_tx_port #(
        .DEPTH        (D),
        .CLKS_PER_BIT (C),
        .OUT_ADDR     (PORT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .TxD       (TxD),
        .Busy      (Busy),
        .Full      (Full),
        .Count     (Count),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: queued characters, sticky overflow, and the frame in flight
    // described only by its character and the number of frame cycles still to run.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] m_ch   = '0;
    int         m_busy = 0;
    logic       m_ovf  = 1'b0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                exp_q.delete();
                m_busy = 0;
                m_ovf  = 1'b0;
            end else begin
                logic qual;
                logic pop_now;
                int   sz;
                sz      = m_q.size();
                qual    = MemWrite && (Addr == PORT) && (WriteData[7:0] != 8'h00);
                pop_now = (m_busy == 0) && (sz > 0);
                if (m_busy > 0) m_busy--;
                if (qual) begin
                    if (sz == D) m_ovf = 1'b1;
                    else m_q.push_back(WriteData[7:0]);
                end
                if (pop_now) begin
                    m_ch = m_q.pop_front();
                    exp_q.push_back(m_ch);
                    m_busy = 10 * C;
                end
            end
        end
    end

    // Expected {TxD, Busy, Full, Overflow, Count} from the model for the current cycle.
    function automatic logic [31:0] exp_vec();
        logic tx;
        int   idx;
        tx = 1'b1;
        if (m_busy > 0) begin
            idx = (10 * C - m_busy) / C;
            if (idx == 0) tx = 1'b0;
            else if (idx <= 8) tx = m_ch[idx-1];
        end
        return {24'd0, tx, (m_busy > 0), (m_q.size() == D), m_ovf, CW'(m_q.size())};
    endfunction

    initial begin : cycle_chk
        forever begin
            @(negedge clk);
            check("cycle_state", {24'd0, TxD, Busy, Full, Overflow, Count}, exp_vec());
        end
    end

    // Serial decoder: samples mid-bit, scores each complete frame against the model's pops.
    initial begin : serial_mon
        logic       prev;
        logic [9:0] frame;
        logic       aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev && !TxD) begin
                frame   = '0;
                aborted = 1'b0;
                for (int t = 0; t < 10 * C; t++) begin
                    if (t > 0) @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (t % C == C / 2) frame[t/C] = TxD;
                end
                if (!aborted) begin
                    check("start_bit", {31'd0, frame[0]}, 32'd0);
                    check("stop_bit", {31'd0, frame[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_frame at %0t: got char 0x%0h, expected none",
                                 $time, frame[8:1]);
                    end else begin
                        check("rx_char", {24'd0, frame[8:1]}, {24'd0, exp_q.pop_front()});
                    end
                    rx_log.push_back(frame[8:1]);
                end
            end
            prev = TxD;
        end
    end

    task automatic drive(input logic we, input logic [10:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        MemWrite  = we;
        Addr      = a;
        WriteData = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            MemWrite = 1'b0;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin : stim
        int         busy_n;
        int         len;
        logic [31:0] d;
        logic [10:0] a;
        logic        we;

        // Reset held for three cycles.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_txd", {31'd0, TxD}, 32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_full", {31'd0, Full}, 32'd0);
        check("rst_count", {28'd0, Count}, 32'd0);
        check("rst_ovf", {31'd0, Overflow}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Single 'H': line falls one cycle after the push edge, frame is 40 cycles.
        rx_log.delete();
        drive(1'b1, PORT, 32'h0000_0048);
        idle(1);
        check("h_txd_hold", {31'd0, TxD}, 32'd1);
        @(posedge clk);
        #2;
        check("h_txd_fall", {31'd0, TxD}, 32'd0);
        busy_n = 0;
        repeat (45) begin
            @(negedge clk);
            if (Busy) busy_n++;
        end
        check("h_busy_len", busy_n, 32'd40);
        idle(5);
        check("h_rx_n", rx_log.size(), 32'd1);
        if (rx_log.size() > 0) check("h_rx_char", {24'd0, rx_log[0]}, 32'h48);

        // Stores that must be ignored.
        drive(1'b1, 11'h3FF, 32'h0000_0041);
        drive(1'b0, PORT, 32'h0000_0042);
        drive(1'b1, PORT, 32'hFFFF_FF00);
        drive(1'b1, 11'h000, 32'h0000_0043);
        idle(3);
        check("ign_count", {28'd0, Count}, 32'd0);
        check("ign_txd", {31'd0, TxD}, 32'd1);
        check("ign_ovf", {31'd0, Overflow}, 32'd0);

        // Ten back-to-back stores 'A'..'J': 'A' pops, 'B'..'I' fill, 'J' overflows.
        rx_log.delete();
        for (int i = 0; i < 10; i++) drive(1'b1, PORT, 32'h41 + 32'(i));
        idle(1);
        check("burst_full", {31'd0, Full}, 32'd1);
        check("burst_count", {28'd0, Count}, 32'd8);
        check("burst_ovf", {31'd0, Overflow}, 32'd1);
        idle(9 * (10 * C + 1) + 20);
        check("burst_rx_n", rx_log.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_log.size()) check("burst_rx_char", {24'd0, rx_log[i]}, 32'h41 + 32'(i));
        end
        check("burst_ovf_sticky", {31'd0, Overflow}, 32'd1);

        // Reset in cycle 15 of a frame: line high at once, queue discarded.
        pulse_reset(2);
        drive(1'b1, PORT, 32'h5A);
        drive(1'b1, PORT, 32'h61);
        drive(1'b1, PORT, 32'h62);
        drive(1'b1, PORT, 32'h63);
        idle(1);
        idle(12);
        check("mid_txd_before", {31'd0, TxD}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_txd_async", {31'd0, TxD}, 32'd1);
        check("mid_count", {28'd0, Count}, 32'd0);
        check("mid_busy", {31'd0, Busy}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rx_log.delete();
        rst = 1'b1;
        idle(50);
        check("mid_no_rx", rx_log.size(), 32'd0);
        drive(1'b1, PORT, 32'h51);
        idle(60);
        check("mid_q_n", rx_log.size(), 32'd1);
        if (rx_log.size() > 0) check("mid_q_char", {24'd0, rx_log[0]}, 32'h51);

        // Randomised bursts with gaps, junk stores and one mid-run reset.
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                d  = $urandom;
                if ($urandom_range(0, 9) == 0) d[7:0] = 8'h00;
                a  = ($urandom_range(0, 9) == 0) ? 11'($urandom) : PORT;
                we = ($urandom_range(0, 9) != 0);
                drive(we, a, d);
            end
            idle($urandom_range(1, 120));
            if (b == 20) pulse_reset(2);
        end
        idle(D * (10 * C + 1) + 60);
        check("drain_exp_empty", exp_q.size(), 32'd0);
        check("drain_idle", {31'd0, Busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
